// File: rtl/score_pulse_gen.sv
// -----------------------------------------------------------------------------
// score_pulse_gen
//
// Feeds the decimal score digit chain. Multi-point scoring events are added to
// a saturating bank, and the bank is drained as single-cycle incr pulses. After
// each pulse the FSM waits GAP idle cycles so that every digit counter sees
// separate increments and has time to handle its carry.
//
// State table
//   state | meaning
//   IDLE  | no pulse in progress; start a pulse when the bank is non-empty and
//         | hold is low
//   PULSE | incr high for exactly one cycle; one banked point is consumed on
//         | the closing edge
//   GAPW  | gap_cnt counts down from GAP-1 to 0; lasts exactly GAP cycles
//
// Ports
//   clk        in   1       system clock, all state on posedge
//   reset      in   1       asynchronous, active-low
//   clear      in   1       synchronous flush of bank, FSM and ovf
//   hold       in   1       blocks the start of new pulses; events still bank
//   ev_valid   in   1       scoring event strobe
//   ev_points  in   PTS_W   points carried by the event (0 = no-op)
//   incr       out  1       one-cycle increment pulse to the units digit
//   busy       out  1       FSM not idle or bank non-empty
//   pending    out  PEND_W  banked points, including the one in flight
//   ovf        out  1       sticky: bank saturated at least once
// -----------------------------------------------------------------------------
module score_pulse_gen #(
    parameter int PTS_W  = 4,
    parameter int PEND_W = 6,
    parameter int GAP    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              hold,
    input  logic              ev_valid,
    input  logic [PTS_W-1:0]  ev_points,
    output logic              incr,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              ovf
);

    // Sum is one bit wider than the widest operand so the add never wraps.
    localparam int SUM_W = ((PTS_W > PEND_W) ? PTS_W : PEND_W) + 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [SUM_W-1:0]  SUM_MAX  = {{(SUM_W-PEND_W){1'b0}}, PEND_MAX};
    localparam logic [SUM_W-1:0]  SUM_ONE  = {{(SUM_W-1){1'b0}}, 1'b1};
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAPW  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [GAP_W-1:0]  gap_cnt, gap_nxt;
    logic [SUM_W-1:0]  sum;
    logic              sat;
    logic [PEND_W-1:0] pending_nxt;
    logic              start_ok;

    // Bank arithmetic: the event add and the pulse decrement land in the same
    // cycle, so a point arriving while one is being emitted is never lost.
    always_comb begin
        sum = {{(SUM_W-PEND_W){1'b0}}, pending};
        if (ev_valid) begin
            sum = sum + {{(SUM_W-PTS_W){1'b0}}, ev_points};
        end
        if (state == PULSE) begin
            sum = sum - SUM_ONE;
        end
        sat         = (sum > SUM_MAX);
        pending_nxt = sat ? PEND_MAX : sum[PEND_W-1:0];
    end

    // Start decisions look at the post-update bank so a fresh event into an
    // idle block pulses on the very next cycle.
    assign start_ok = (pending_nxt != '0) && !hold;

    // State register and bank
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            gap_cnt <= '0;
            pending <= '0;
            ovf     <= 1'b0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_nxt;
            if (clear) begin
                pending <= '0;
                ovf     <= 1'b0;
            end else begin
                pending <= pending_nxt;
                ovf     <= ovf | sat;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        if (clear) begin
            state_nxt = IDLE;
            gap_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state_nxt = PULSE;
                    end
                end
                PULSE: begin
                    if (GAP > 0) begin
                        state_nxt = GAPW;
                        gap_nxt   = GAP_LOAD;
                    end else begin
                        state_nxt = start_ok ? PULSE : IDLE;
                    end
                end
                GAPW: begin
                    if (gap_cnt != '0) begin
                        gap_nxt = gap_cnt - GAP_ONE;
                    end else begin
                        state_nxt = start_ok ? PULSE : IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    gap_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        incr = (state == PULSE);
        busy = (state != IDLE) || (pending != '0);
    end

endmodule

// File: tb/tb_score_pulse_gen.sv
module tb_score_pulse_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       hold;
    logic       ev_valid_a, ev_valid_b;
    logic [3:0] ev_points_a, ev_points_b;
    logic       incr_a, busy_a, ovf_a;
    logic       incr_b, busy_b, ovf_b;
    logic [5:0] pending_a, pending_b;

    int n_tests = 0;
    int n_fail  = 0;
    int units_a = 0;
    int units_b = 0;

    always #5 clk = ~clk;

    score_pulse_gen #(.PTS_W(4), .PEND_W(6), .GAP(2)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .hold      (hold),
        .ev_valid  (ev_valid_a),
        .ev_points (ev_points_a),
        .incr      (incr_a),
        .busy      (busy_a),
        .pending   (pending_a),
        .ovf       (ovf_a)
    );

    score_pulse_gen #(.PTS_W(4), .PEND_W(6), .GAP(0)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .hold      (hold),
        .ev_valid  (ev_valid_b),
        .ev_points (ev_points_b),
        .incr      (incr_b),
        .busy      (busy_b),
        .pending   (pending_b),
        .ovf       (ovf_b)
    );

    // Downstream units digit model: one count per cycle with incr high.
    always @(negedge clk) begin
        if (incr_a) units_a++;
        if (incr_b) units_b++;
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ev_a(input int pts);
        ev_valid_a  = 1'b1;
        ev_points_a = 4'(pts);
        step();
        ev_valid_a  = 1'b0;
        ev_points_a = 4'd0;
    endtask

    task automatic wait_idle_a(input int budget);
        int k;
        k = 0;
        while (busy_a && k < budget) begin
            step();
            k++;
        end
        check_val("idle_a_timeout", int'(busy_a), 0);
    endtask

    int t1_incr[10] = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 0};
    int t1_pend[10] = '{3, 2, 2, 2, 1, 1, 1, 0, 0, 0};
    int t1_busy[10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int t5_incr[5]  = '{1, 1, 1, 1, 0};
    int t5_pend[5]  = '{4, 3, 2, 1, 0};

    initial begin
        reset       = 1'b0;
        clear       = 1'b0;
        hold        = 1'b0;
        ev_valid_a  = 1'b0;
        ev_points_a = 4'd0;
        ev_valid_b  = 1'b0;
        ev_points_b = 4'd0;

        #2;
        check_val("rst_incr",    int'(incr_a),    0);
        check_val("rst_busy",    int'(busy_a),    0);
        check_val("rst_pending", int'(pending_a), 0);
        check_val("rst_ovf",     int'(ovf_a),     0);

        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        step();

        // 3-point event, GAP=2: pulses at t+1, t+4, t+7; idle at t+10
        ev_valid_a  = 1'b1;
        ev_points_a = 4'd3;
        for (int i = 0; i < 10; i++) begin
            step();
            ev_valid_a  = 1'b0;
            ev_points_a = 4'd0;
            check_val($sformatf("t1_incr_%0d", i + 1), int'(incr_a), t1_incr[i]);
            check_val($sformatf("t1_pend_%0d", i + 1), int'(pending_a), t1_pend[i]);
            check_val($sformatf("t1_busy_%0d", i + 1), int'(busy_a), t1_busy[i]);
        end

        // ev_points==0 is a no-op
        ev_a(0);
        check_val("zero_busy",    int'(busy_a),    0);
        check_val("zero_incr",    int'(incr_a),    0);
        check_val("zero_pending", int'(pending_a), 0);

        // Event arriving during a PULSE cycle: add and decrement both apply
        units_a = 0;
        ev_a(2);
        check_val("t2_incr_first", int'(incr_a),    1);
        check_val("t2_pend_first", int'(pending_a), 2);
        ev_a(4);
        check_val("t2_pend_merge", int'(pending_a), 5);
        check_val("t2_incr_gap",   int'(incr_a),    0);
        wait_idle_a(100);
        check_val("t2_units", units_a, 6);

        // hold blocks pulse start; release pulses next cycle; gap end under hold idles
        hold = 1'b1;
        ev_a(2);
        check_val("t4_incr_hold", int'(incr_a),    0);
        check_val("t4_pend_hold", int'(pending_a), 2);
        check_val("t4_busy_hold", int'(busy_a),    1);
        step();
        check_val("t4_incr_hold2", int'(incr_a), 0);
        hold = 1'b0;
        step();
        check_val("t4_incr_rel", int'(incr_a),    1);
        check_val("t4_pend_rel", int'(pending_a), 2);
        hold = 1'b1;
        step();
        step();
        step();
        check_val("t4_incr_gapend", int'(incr_a),    0);
        check_val("t4_pend_gapend", int'(pending_a), 1);
        check_val("t4_busy_gapend", int'(busy_a),    1);
        hold = 1'b0;
        step();
        check_val("t4_incr_rel2", int'(incr_a),    1);
        check_val("t4_pend_rel2", int'(pending_a), 1);
        wait_idle_a(100);

        // Saturation and clear
        hold = 1'b1;
        repeat (4) ev_a(15);
        check_val("t3_pend_60", int'(pending_a), 60);
        check_val("t3_ovf_60",  int'(ovf_a),     0);
        check_val("t3_incr_60", int'(incr_a),    0);
        ev_a(15);
        check_val("t3_pend_sat", int'(pending_a), 63);
        check_val("t3_ovf_sat",  int'(ovf_a),     1);
        clear       = 1'b1;
        ev_valid_a  = 1'b1;
        ev_points_a = 4'd15;
        step();
        clear       = 1'b0;
        ev_valid_a  = 1'b0;
        ev_points_a = 4'd0;
        check_val("t3_pend_clr", int'(pending_a), 0);
        check_val("t3_ovf_clr",  int'(ovf_a),     0);
        check_val("t3_busy_clr", int'(busy_a),    0);
        hold = 1'b0;
        step();
        check_val("t3_incr_clr", int'(incr_a), 0);

        // GAP=0: back-to-back pulses
        units_b     = 0;
        ev_valid_b  = 1'b1;
        ev_points_b = 4'd4;
        for (int i = 0; i < 5; i++) begin
            step();
            ev_valid_b  = 1'b0;
            ev_points_b = 4'd0;
            check_val($sformatf("t5_incr_%0d", i + 1), int'(incr_b), t5_incr[i]);
            check_val($sformatf("t5_pend_%0d", i + 1), int'(pending_b), t5_pend[i]);
        end
        check_val("t5_units", units_b, 4);
        check_val("t5_busy",  int'(busy_b), 0);

        // Async reset mid-burst with ovf set
        hold = 1'b1;
        repeat (5) ev_a(15);
        check_val("t6_pend_sat", int'(pending_a), 63);
        check_val("t6_ovf_sat",  int'(ovf_a),     1);
        hold = 1'b0;
        step();
        check_val("t6_incr_run", int'(incr_a),    1);
        check_val("t6_pend_run", int'(pending_a), 63);
        step();
        check_val("t6_pend_mid", int'(pending_a), 62);
        #2 reset = 1'b0;
        #1;
        check_val("t6_incr_rst", int'(incr_a),    0);
        check_val("t6_busy_rst", int'(busy_a),    0);
        check_val("t6_pend_rst", int'(pending_a), 0);
        check_val("t6_ovf_rst",  int'(ovf_a),     0);
        @(posedge clk);
        #1 reset = 1'b1;
        step();
        check_val("t6_incr_after", int'(incr_a), 0);
        check_val("t6_busy_after", int'(busy_a), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
